// File: rtl/pulse_stim_gen_if.sv
// Sample-stream interface of the detector-pulse emulator: pulse request and
// configuration in, emulated samples and status strobes out.
interface pulse_stim_gen_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] amplitude;
  logic [15:0]       period;
  logic [DATA_W-1:0] output_data;
  logic              busy;
  logic              pileup_err;

  modport master (
    output start, amplitude, period,
    input  output_data, busy, pileup_err
  );

  modport slave (
    input  start, amplitude, period,
    output output_data, busy, pileup_err
  );
endinterface

// File: rtl/pulse_stim_gen.sv
// Detector-pulse emulator: linear rise, exponential decay, constant baseline.
// Optional feature macro: NOISE_EN adds LFSR noise (-4..+3) to every sample.
module pulse_stim_gen #(
  parameter int DATA_W      = 16,
  parameter int BASELINE    = 0,
  parameter int RISE_SHIFT  = 0,
  parameter int DECAY_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pulse_stim_gen_if.slave      bus
);

  localparam int                CNT_W     = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
  localparam logic [CNT_W-1:0]  RISE_LAST = CNT_W'((1 << RISE_SHIFT) - 1);
  localparam logic [DATA_W-1:0] DECAY_MIN = DATA_W'(1 << DECAY_SHIFT);
  localparam logic [DATA_W-1:0] MAX_VAL   = '1;
  localparam logic [DATA_W:0]   BASE_EXT  = (DATA_W+1)'(BASELINE);

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    DECAY
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  rise_cnt_q, rise_cnt_d;
  logic [15:0]       per_cnt_q, per_cnt_d;
  logic              running_q, running_d;
  logic [DATA_W-1:0] output_q, out_d;
  logic              busy_q;
  logic              pileup_q, pileup_d;

  logic              auto_trig;
  logic              trig;
  logic              accepted;
  logic [DATA_W:0]   rise_sum;
  logic [DATA_W-1:0] rise_val;
  logic [DATA_W:0]   base_sum;

  assign auto_trig = (bus.period != 16'd0) && running_q
                     && (per_cnt_q == bus.period - 16'd1);
  assign trig      = bus.start | auto_trig;
  // A trigger arriving during the rise is dropped, so it must not restart the repeat timer.
  assign accepted  = trig && (state_q != RISE);

  assign rise_sum  = {1'b0, acc_q} + {1'b0, step_q};
  assign rise_val  = rise_sum[DATA_W] ? MAX_VAL : rise_sum[DATA_W-1:0];

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    acc_d      = acc_q;
    step_d     = step_q;
    rise_cnt_d = rise_cnt_q;
    pileup_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          step_d     = bus.amplitude >> RISE_SHIFT;
          rise_cnt_d = '0;
          state_d    = RISE;
        end
      end
      RISE: begin
        acc_d      = rise_val;
        rise_cnt_d = rise_cnt_q + CNT_W'(1);
        pileup_d   = trig;
        // A zero-amplitude pulse has nothing to decay, so it ends with the rise.
        if (rise_cnt_q == RISE_LAST) state_d = (rise_val == '0) ? IDLE : DECAY;
      end
      DECAY: begin
        if (trig) begin
          step_d     = bus.amplitude >> RISE_SHIFT;
          rise_cnt_d = '0;
          state_d    = RISE;
        end else if (acc_q < DECAY_MIN) begin
          // Below this the shifted decrement is zero and the tail would never finish.
          acc_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d = acc_q - (acc_q >> DECAY_SHIFT);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    per_cnt_d = accepted ? 16'd0 : per_cnt_q + 16'd1;
    running_d = running_q | accepted;
  end

  assign base_sum = BASE_EXT + {1'b0, acc_d};

`ifdef NOISE_EN
  logic [15:0]              lfsr_q;
  logic signed [DATA_W+1:0] noisy;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_comb begin
    noisy = signed'({1'b0, base_sum}) + signed'({{(DATA_W-1){lfsr_q[2]}}, lfsr_q[2:0]});
    if (noisy < 0)                                  out_d = '0;
    else if (noisy > signed'({2'b00, MAX_VAL}))     out_d = MAX_VAL;
    else                                            out_d = noisy[DATA_W-1:0];
  end
`else
  assign out_d = base_sum[DATA_W] ? MAX_VAL : base_sum[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      step_q     <= '0;
      rise_cnt_q <= '0;
      per_cnt_q  <= '0;
      running_q  <= 1'b0;
      output_q   <= DATA_W'(BASELINE);
      busy_q     <= 1'b0;
      pileup_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      rise_cnt_q <= rise_cnt_d;
      per_cnt_q  <= per_cnt_d;
      running_q  <= running_d;
      output_q   <= out_d;
      busy_q     <= (state_d != IDLE);
      pileup_q   <= pileup_d;
    end
  end

  assign bus.output_data = output_q;
  assign bus.busy        = busy_q;
  assign bus.pileup_err  = pileup_q;

endmodule

// File: tb/tb_pulse_stim_gen.sv
// Directed bench for pulse_stim_gen: three instances cover the default build,
// a 4-cycle rise and a high baseline that drives the output into saturation.
module tb_pulse_stim_gen;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;

  always #5 clk = ~clk;

  pulse_stim_gen_if if0 ();
  pulse_stim_gen_if ifr ();
  pulse_stim_gen_if ifb ();

  pulse_stim_gen dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (if0)
  );

  pulse_stim_gen #(.RISE_SHIFT(2)) dut_r (
    .clk   (clk),
    .reset (rst),
    .bus   (ifr)
  );

  pulse_stim_gen #(.BASELINE(65000)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_r[6] = '{100, 200, 300, 400, 375, 352};
  int o[1:102];
  int m;
  int busy_seen;
  bit done;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle0(input string tag);
    for (int i = 0; i < 300 && if0.busy; i++) step();
    check(tag, if0.busy, 0);
  endtask

  initial begin
    // Reset held with start asserted: nothing may be emitted.
    rst = 1'b1; rst_b = 1'b1;
    if0.start = 1'b1; if0.amplitude = 16'd1600; if0.period = 16'd0;
    ifr.start = 1'b1; ifr.amplitude = 16'd400;  ifr.period = 16'd0;
    ifb.start = 1'b1; ifb.amplitude = 16'd1000; ifb.period = 16'd0;
    repeat (3) step();
    check("rst_out0", if0.output_data, 0);
    check("rst_busy0", if0.busy, 0);
    check("rst_out_b", ifb.output_data, 65000);
    rst = 1'b0; rst_b = 1'b0;
    if0.start = 1'b0; ifr.start = 1'b0; ifb.start = 1'b0;
    step();
    check("idle_out0", if0.output_data, 0);
    check("idle_busy0", if0.busy, 0);
    check("idle_out_b", ifb.output_data, 65000);

    // Single-shot pulse, full decay tail to zero.
    if0.amplitude = 16'd1600; if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    check("t2_busy_rise", if0.busy, 1);
    step(); check("t2_peak", if0.output_data, 1600);
    step(); check("t2_dec1", if0.output_data, 1500);
    step(); check("t2_dec2", if0.output_data, 1407);
    m = 1407; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      m = (m < 16) ? 0 : m - (m >> 4);
      check("t2_decay", if0.output_data, m);
      if (m == 0) begin
        check("t2_busy_drop", if0.busy, 0);
        done = 1'b1;
      end
    end
    check("t2_tail_end", done, 1);
    repeat (10) step();
    check("t2_no_repeat_out", if0.output_data, 0);
    check("t2_no_repeat_busy", if0.busy, 0);

    // Pile-up during decay: rise restarts from the current accumulator.
    if0.amplitude = 16'd1600; if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    step(); step(); step();
    check("t4_pre", if0.output_data, 1407);
    if0.amplitude = 16'd1000; if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    check("t4_no_err_decay", if0.pileup_err, 0);
    step(); check("t4_pileup_sum", if0.output_data, 2407);
    step(); check("t4_pileup_dec", if0.output_data, 2257);
    wait_idle0("t4_idle");

    // Start during rise is dropped and flagged.
    if0.amplitude = 16'd1600; if0.start = 1'b1;
    step();
    if0.amplitude = 16'd500;
    step();
    if0.start = 1'b0;
    check("t4_rise_err", if0.pileup_err, 1);
    check("t4_rise_out", if0.output_data, 1600);
    step();
    check("t4_err_strobe", if0.pileup_err, 0);
    check("t4_rise_dec", if0.output_data, 1500);
    wait_idle0("t4_idle2");

    // Zero amplitude: one busy cycle, output stays at baseline.
    if0.amplitude = 16'd0; if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    check("amp0_busy", if0.busy, 1);
    check("amp0_out", if0.output_data, 0);
    step();
    check("amp0_busy_end", if0.busy, 0);
    check("amp0_out_end", if0.output_data, 0);

    // Auto-repeat every 50 cycles, then stop it.
    if0.amplitude = 16'd800; if0.period = 16'd50; if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    for (int k = 1; k <= 102; k++) begin
      step();
      o[k] = int'(if0.output_data);
    end
    if0.period = 16'd0;
    m = 800;
    repeat (48) m = m - (m >> 4);
    check("t5_peak1", o[1], 800);
    check("t5_peak2", o[51], m + 800);
    check("t5_rise2", int'(o[51] > o[50]), 1);
    check("t5_fall2", int'(o[52] < o[51]), 1);
    check("t5_rise3", int'(o[101] > o[100]), 1);
    check("t5_fall3", int'(o[102] < o[101]), 1);
    wait_idle0("t5_idle");
    busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (if0.busy) busy_seen++;
    end
    check("t5_stopped", busy_seen, 0);

    // Four-cycle linear rise.
    ifr.amplitude = 16'd400; ifr.start = 1'b1;
    step();
    ifr.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("t3_sample%0d", i), ifr.output_data, exp_r[i]);
    end

    // High baseline saturates; reset mid-decay aborts the pulse.
    ifb.amplitude = 16'd1000; ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    step();
    check("t6_sat_peak", ifb.output_data, 65535);
    check("t6_busy", ifb.busy, 1);
    step(); check("t6_sat_dec", ifb.output_data, 65535);
    step();
    rst_b = 1'b1;
    step();
    check("t6_rst_out", ifb.output_data, 65000);
    check("t6_rst_busy", ifb.busy, 0);
    rst_b = 1'b0;
    step();
    check("t6_post_out", ifb.output_data, 65000);
    check("t6_post_busy", ifb.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
